// File: rtl/sram_bus_master.sv
// sram_bus_master: initiator for a single-port synchronous RAM bus.
//
// Accepts read/write requests on a valid/ready interface and sequences the
// RAM bus cycles. Writes complete silently at one per cycle; reads return data
// on a one-cycle rsp_valid pulse. Out-of-range requests get an error pulse
// and never touch the RAM.
//
// Ports:
//   clk, rst     - clock (rising edge) and asynchronous active-high reset
//   req_valid    - client request present
//   req_ready    - a request is accepted on this cycle's edge if req_valid
//   req_write    - 1 = write, 0 = read
//   req_addr     - request address
//   req_wdata    - write data
//   rsp_valid    - one-cycle pulse: read completed or request errored
//   rsp_rdata    - read data, held until the next rsp_valid
//   rsp_err      - qualifies rsp_valid: out-of-range access
//   mem_addr     - RAM address (registered)
//   mem_data     - RAM data bus, driven only while writing
//   mem_cs       - RAM chip select (registered)
//   mem_we       - RAM write enable (registered)
//   mem_oe       - RAM output enable (registered)

module sram_bus_master #(
    parameter int unsigned ADDRWIDTH = 4,
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned SIZE      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDRWIDTH-1:0] req_addr,
    input  logic [DATAWIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDRWIDTH-1:0] mem_addr,
    inout  wire  [DATAWIDTH-1:0] mem_data,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic                 mem_oe
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdAddr,
        StRdData,
        StTurn,
        StErr
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
    logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   cs_q, cs_d;
    logic                   we_q, we_d;
    logic                   oe_q, oe_d;
    logic                   drive_q, drive_d;
    logic                   handshake;
    logic                   in_range;

    // Widened compare so SIZE == 2**ADDRWIDTH never flags an error.
    assign in_range  = 64'(req_addr) < 64'(SIZE);
    assign req_ready = !rst && ((state_q == StIdle) || (state_q == StWrite));
    assign handshake = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            StIdle, StWrite: begin
                if (handshake) begin
                    if (!in_range) begin
                        // mem_addr is left as is: the bus is not touched.
                        state_d     = StErr;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        addr_d = req_addr;
                        if (req_write) begin
                            state_d = StWrite;
                            wdata_d = req_wdata;
                        end else begin
                            state_d = StRdAddr;
                        end
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRdAddr: state_d = StRdData;
            StRdData: begin
                // RAM drives the bus this cycle; capture on the exiting edge.
                state_d     = StTurn;
                rdata_d     = mem_data;
                rsp_valid_d = 1'b1;
            end
            StTurn:   state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Bus controls are registered from the next state so they line up
        // exactly with the state they belong to.
        cs_d    = (state_d == StWrite) || (state_d == StRdAddr) || (state_d == StRdData);
        we_d    = (state_d == StWrite);
        oe_d    = (state_d == StRdData);
        drive_d = (state_d == StWrite);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            drive_q     <= drive_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_cs    = cs_q;
    assign mem_we    = we_q;
    assign mem_oe    = oe_q;
    assign mem_data  = drive_q ? wdata_q : 'z;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_bus_master.sv
// Testbench for sram_bus_master with a behavioural RAM on the bus and a
// transaction-level reference model (word array + expected-response queue).

module tb_sram_bus_master;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned SZ = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;

    always #5 clk = ~clk;

    sram_bus_master #(
        .ADDRWIDTH(AW),
        .DATAWIDTH(DW),
        .SIZE     (SZ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_oe   (mem_oe)
    );

    // Behavioural synchronous RAM: write on cs&we edge, output register
    // loaded on cs&!we edges, driven onto the bus while cs&oe.
    logic [DW-1:0] ram [16];
    logic [DW-1:0] ram_dout;
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_data;
            else        ram_dout <= ram[mem_addr];
        end
    end
    assign mem_data = (mem_cs && mem_oe) ? ram_dout : 'z;

    // Monitor: cycle count, handshakes, bus activity, observed responses.
    typedef struct packed {
        logic [31:0]   cyc;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    int   cyc_cnt    = 0;
    int   hs_count   = 0;
    int   cs_cycles  = 0;
    int   we_cycles  = 0;
    int   bus_viol   = 0;
    rsp_t obs_q[$];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (req_valid && req_ready) hs_count <= hs_count + 1;
    end

    always @(negedge clk) begin
        if (mem_cs) cs_cycles <= cs_cycles + 1;
        if (mem_we) we_cycles <= we_cycles + 1;
        // Master drives only with we, RAM only with oe: both at once is contention.
        if ((mem_we && mem_oe) || ((mem_we || mem_oe) && !mem_cs)) bus_viol <= bus_viol + 1;
        if (rsp_valid) obs_q.push_back({32'(cyc_cnt), rsp_err, rsp_rdata});
    end

    // Reference model.
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] ref_last = '0;
    rsp_t          exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (6) tick();
    endtask

    // Present a request, wait (bounded) for acceptance and update the model.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit keep);
        int   waited = 0;
        rsp_t e;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready,
                     waited);
            req_valid = 1'b0;
            return;
        end
        tick();
        if (32'(a) >= SZ) begin
            e = {32'(cyc_cnt), 1'b1, ref_last};
            exp_q.push_back(e);
        end else if (wr) begin
            ref_mem[a] = d;
        end else begin
            ref_last = ref_mem[a];
            e = {32'(cyc_cnt + 2), 1'b0, ref_last};
            exp_q.push_back(e);
        end
        if (!keep) begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        tick();
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %0b, required 0", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%0b err=%0b rdata=%02h, required all 0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if ({mem_cs, mem_we, mem_oe, mem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_mem: got cs=%0b we=%0b oe=%0b addr=%0d, required all 0",
                     mem_cs, mem_we, mem_oe, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %0b, required 1", req_ready);
        end
        obs_q.delete();
    endtask

    task automatic test_single();
        int   we0, cs0;
        rsp_t e, o;
        we0 = we_cycles;
        cs0 = cs_cycles;
        issue(1'b1, 4'd2, 8'h5A, 1'b0);
        settle();
        checks++;
        if (we_cycles - we0 != 1 || cs_cycles - cs0 != 1) begin
            errors++;
            $display("FAIL single_write_strobe: we cycles=%0d cs cycles=%0d, required 1 and 1",
                     we_cycles - we0, cs_cycles - cs0);
        end
        issue(1'b0, 4'd2, 8'h00, 1'b0);
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL single_rsp: no response, required cyc=%0d err=%0b rdata=%02h",
                         e.cyc, e.err, e.rdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL single_rsp: got cyc=%0d err=%0b rdata=%02h, required cyc=%0d err=%0b rdata=%02h",
                             o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0 || rsp_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL single_hold: extra rsps=%0d rdata=%02h, required 0 and 5a",
                     obs_q.size(), rsp_rdata);
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int   we0, first_cyc, ready_drops;
        rsp_t e, o;
        we0         = we_cycles;
        ready_drops = 0;
        first_cyc   = 0;
        for (int a = 0; a < int'(SZ); a++) begin
            issue(1'b1, AW'(a), DW'(a) ^ 8'hFF, a != int'(SZ) - 1);
            if (a == 0) first_cyc = cyc_cnt;
            if (a != int'(SZ) - 1 && req_ready !== 1'b1) ready_drops++;
        end
        checks++;
        if (cyc_cnt - first_cyc != int'(SZ) - 1 || ready_drops != 0) begin
            errors++;
            $display("FAIL b2b_rate: span=%0d drops=%0d, required span %0d drops 0",
                     cyc_cnt - first_cyc, ready_drops, SZ - 1);
        end
        settle();
        checks++;
        if (we_cycles - we0 != int'(SZ)) begin
            errors++;
            $display("FAIL b2b_we_cycles: got %0d, required %0d", we_cycles - we0, SZ);
        end
        for (int a = 0; a < int'(SZ); a++) issue(1'b0, AW'(a), 8'h00, 1'b0);
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL b2b_rsp: no response, required cyc=%0d err=%0b rdata=%02h",
                         e.cyc, e.err, e.rdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b_rsp: got cyc=%0d err=%0b rdata=%02h, required cyc=%0d err=%0b rdata=%02h",
                             o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_write_then_read();
        rsp_t e, o;
        issue(1'b1, 4'd7, 8'h11, 1'b1);
        issue(1'b0, 4'd7, 8'h00, 1'b0);
        tick();
        tick();
        checks++;
        if (mem_cs !== 1'b0 || mem_oe !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL turn_cycle: cs=%0b oe=%0b ready=%0b, required 0 0 0",
                     mem_cs, mem_oe, req_ready);
        end
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL wr_rd_rsp: no response, required cyc=%0d err=%0b rdata=%02h",
                         e.cyc, e.err, e.rdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL wr_rd_rsp: got cyc=%0d err=%0b rdata=%02h, required cyc=%0d err=%0b rdata=%02h",
                             o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_abort();
        rsp_t e, o;
        issue(1'b1, 4'd3, 8'h3C, 1'b0);
        settle();
        issue(1'b1, 4'd3, 8'hA5, 1'b0);
        // Now in the write cycle; the write must not land.
        ref_mem[3] = 8'h3C;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_cs, mem_we, mem_oe, req_ready, rsp_valid, rsp_err} !== '0 ||
            mem_addr !== '0 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL abort_outputs: cs=%0b we=%0b oe=%0b rdy=%0b v=%0b e=%0b a=%0d d=%02h, required all 0",
                     mem_cs, mem_we, mem_oe, req_ready, rsp_valid, rsp_err, mem_addr, rsp_rdata);
        end
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        ref_last = '0;
        obs_q.delete();
        tick();
        issue(1'b0, 4'd3, 8'h00, 1'b0);
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL abort_rsp: no response, required cyc=%0d err=%0b rdata=%02h",
                         e.cyc, e.err, e.rdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL abort_rsp: got cyc=%0d err=%0b rdata=%02h, required cyc=%0d err=%0b rdata=%02h",
                             o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_out_of_range();
        int   cs0;
        rsp_t e, o;
        issue(1'b0, 4'd5, 8'h00, 1'b0);
        settle();
        cs0 = cs_cycles;
        issue(1'b1, 4'd13, 8'h77, 1'b0);
        issue(1'b0, 4'd14, 8'h00, 1'b0);
        issue(1'b0, 4'd12, 8'h00, 1'b0);
        settle();
        checks++;
        if (cs_cycles != cs0) begin
            errors++;
            $display("FAIL oor_cs: cs high %0d cycles, required 0", cs_cycles - cs0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL oor_rsp: no response, required cyc=%0d err=%0b rdata=%02h",
                         e.cyc, e.err, e.rdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL oor_rsp: got cyc=%0d err=%0b rdata=%02h, required cyc=%0d err=%0b rdata=%02h",
                             o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_stall();
        int            hs0;
        logic [DW-1:0] d;
        rsp_t          e, o;
        d = DW'($urandom);
        issue(1'b0, 4'd4, 8'h00, 1'b1);
        req_write = 1'b1;
        req_addr  = 4'd9;
        req_wdata = d;
        hs0       = hs_count;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got %0b, required 0", i, req_ready);
            end
            tick();
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got %0b, required 1", req_ready);
        end
        issue(1'b1, 4'd9, d, 1'b0);
        settle();
        checks++;
        if (hs_count - hs0 != 1) begin
            errors++;
            $display("FAIL stall_accept_once: got %0d handshakes, required 1", hs_count - hs0);
        end
        issue(1'b0, 4'd9, 8'h00, 1'b0);
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL stall_rsp: no response, required cyc=%0d err=%0b rdata=%02h",
                         e.cyc, e.err, e.rdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL stall_rsp: got cyc=%0d err=%0b rdata=%02h, required cyc=%0d err=%0b rdata=%02h",
                             o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_random();
        bit   keep;
        rsp_t e, o;
        for (int i = 0; i < 60; i++) begin
            keep = 1'($urandom);
            issue(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), keep);
            if (!keep) repeat ($urandom_range(0, 2)) tick();
        end
        req_valid = 1'b0;
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL random_rsp: no response, required cyc=%0d err=%0b rdata=%02h",
                         e.cyc, e.err, e.rdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL random_rsp: got cyc=%0d err=%0b rdata=%02h, required cyc=%0d err=%0b rdata=%02h",
                             o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL random_extra: %0d unexpected responses, required 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_bus_protocol();
        checks++;
        if (bus_viol != 0) begin
            errors++;
            $display("FAIL bus_protocol: %0d cycles with bad cs/we/oe mix, required 0", bus_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_write_then_read();
        test_reset_abort();
        test_out_of_range();
        test_stall();
        test_random();
        test_bus_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
